// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: iterative signed/unsigned multiply and divide for the EX stage.
// One iteration per clock, start/done handshake, pipeline stall while computing,
// HI/LO results held for the hilo_reg write path.
//
// state | meaning
// IDLE  | waiting for start_i; results held
// CALC  | one shift-add or restoring-divide step per clock
// DONE  | done_o high for this single cycle; start_i ignored
module muldiv_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   mag_a_q;
    logic [WIDTH-1:0]   mag_b_q;
    // MUL: full product accumulator; DIV: low half holds the dividend shifting
    // out MSB first while quotient bits shift in from the bottom.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;

    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic               div_by_zero;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   div_trial;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;

    // Operand decode at the start request: magnitudes and sign bookkeeping.
    always_comb begin
        op_signed   = ~op_i[0];
        a_neg       = op_signed & a_i[WIDTH-1];
        b_neg       = op_signed & b_i[WIDTH-1];
        mag_a_in    = a_neg ? (~a_i + 1'b1) : a_i;
        mag_b_in    = b_neg ? (~b_i + 1'b1) : b_i;
        div_by_zero = op_i[1] & (b_i == '0);
    end

    // One multiply step and one restoring-divide step, plus the sign-corrected
    // results that are captured on the final iteration.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        // The shifted partial remainder needs W+1 bits; after a successful
        // subtract the difference is below the divisor, so W bits suffice.
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, mag_b_q});
        div_trial = div_shift[WIDTH-1:0] - mag_b_q;
        rem_next  = div_ok ? div_trial : div_shift[WIDTH-1:0];
        quo_next  = {acc_q[WIDTH-2:0], div_ok};

        prod_fin  = neg_res_q ? (~mul_next + 1'b1) : mul_next;
        quo_fin   = neg_res_q ? (~quo_next + 1'b1) : quo_next;
        rem_fin   = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
    end

    // Handshake outputs derived from the current state.
    always_comb begin
        busy_o  = (state_q != ST_IDLE);
        stall_o = ((state_q == ST_IDLE) & start_i & ~annul_i) | (state_q == ST_CALC);
    end

    // Sequencer, datapath registers and registered result outputs.
    always_ff @(posedge clka) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_o     <= 1'b0;
                    div_zero_o <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (div_by_zero) begin
                            state_q    <= ST_DONE;
                            hi_o       <= a_i;
                            lo_o       <= '1;
                            done_o     <= 1'b1;
                            div_zero_o <= 1'b1;
                        end else begin
                            state_q   <= ST_CALC;
                            cnt_q     <= '0;
                            is_div_q  <= op_i[1];
                            neg_res_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            mag_a_q   <= mag_a_in;
                            mag_b_q   <= mag_b_in;
                            rem_q     <= '0;
                            acc_q     <= {{WIDTH{1'b0}}, (op_i[1] ? mag_a_in : mag_b_in)};
                        end
                    end
                end
                ST_CALC: begin
                    if (annul_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (is_div_q) begin
                            acc_q <= {acc_q[2*WIDTH-1:WIDTH], quo_next};
                            rem_q <= rem_next;
                        end else begin
                            acc_q <= mul_next;
                        end
                        if (cnt_q == LAST_CNT) begin
                            state_q <= ST_DONE;
                            done_o  <= 1'b1;
                            if (is_div_q) begin
                                hi_o <= rem_fin;
                                lo_o <= quo_fin;
                            end else begin
                                hi_o <= prod_fin[2*WIDTH-1:WIDTH];
                                lo_o <= prod_fin[WIDTH-1:0];
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    done_o     <= 1'b0;
                    div_zero_o <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
